// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single full-subtractor cell and a borrow flop.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sa_q, sb_q, sd_q;
  logic             br_q;
  logic [CntW-1:0]  cnt_q;

  logic             x, y, d, br_d;
  logic [WIDTH-1:0] sd_d;

  // sd_q[0] is the oldest bit and falls off the end on every shift.
  logic unused_sd;
  assign unused_sd = sd_q[0];

  always_comb begin
    x    = sa_q[0];
    y    = sb_q[0];
    d    = x ^ y ^ br_q;
    br_d = (~x & y) | (~(x ^ y) & br_q);
    sd_d = {d, sd_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      sd_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff    <= '0;
      bout    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            state_q <= StShift;
          end else begin
            state_q <= StIdle;
          end
        end
        StShift: begin
          sa_q  <= {1'b0, sa_q[WIDTH-1:1]};
          sb_q  <= {1'b0, sb_q[WIDTH-1:1]};
          sd_q  <= sd_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            diff    <= sd_d;
            bout    <= br_d;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Decoded purely from state so start can never reach busy/done combinationally.
  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=4 and WIDTH=8.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a, b;
  logic       bin;
  logic       busy, done;
  logic [3:0] diff;
  logic       bout;

  logic       start8;
  logic [7:0] a8, b8;
  logic       bin8;
  logic       busy8, done8;
  logic [7:0] diff8;
  logic       bout8;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  serial_subtractor #(.WIDTH(4)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .bin   (bin8),
    .busy  (busy8),
    .done  (done8),
    .diff  (diff8),
    .bout  (bout8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One WIDTH=4 operation issued from idle; checks latency, done pulse and result.
  task automatic do_op(input logic [3:0] ta, input logic [3:0] tb, input logic tbin,
                       input string tag);
    logic [4:0] exp;
    int cyc;
    exp = {1'b0, ta} - {1'b0, tb} - {4'b0, tbin};
    @(negedge clk);
    start = 1'b1; a = ta; b = tb; bin = tbin;
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tb; bin = ~tbin;
    cyc = 0;
    while (busy && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    check_val({tag, "_lat"}, cyc, 4);
    check_val({tag, "_done"}, {busy, done}, 2'b01);
    check_val({tag, "_res"}, {bout, diff}, exp);
  endtask

  task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                        input string tag);
    logic [8:0] exp;
    int cyc;
    exp = {1'b0, ta} - {1'b0, tb} - {8'b0, tbin};
    @(negedge clk);
    start8 = 1'b1; a8 = ta; b8 = tb; bin8 = tbin;
    @(negedge clk);
    start8 = 1'b0; a8 = ~ta; b8 = ~tb;
    cyc = 0;
    while (busy8 && cyc < 30) begin
      cyc++;
      @(negedge clk);
    end
    check_val({tag, "_lat"}, cyc, 8);
    check_val({tag, "_done"}, done8, 1);
    check_val({tag, "_res"}, {bout8, diff8}, exp);
  endtask

  logic [3:0] pa [4] = '{4'd9, 4'd3, 4'd0, 4'd15};
  logic [3:0] pb [4] = '{4'd3, 4'd9, 4'd0, 4'd15};
  logic       pc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int last;
    int w;
    int pulses;
    logic [4:0] exp;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset_outs", {busy, done, bout, diff}, 7'h00);
    check_val("reset_outs8", {busy8, done8, bout8, diff8}, 11'h000);
    rst = 1'b0;

    do_op(4'd9, 4'd3, 1'b0, "a9b3");
    @(negedge clk);
    check_val("done_one_cycle", {busy, done}, 2'b00);
    check_val("hold_after_done", {bout, diff}, 5'h06);
    do_op(4'd3, 4'd9, 1'b0, "a3b9");
    do_op(4'd0, 4'd0, 1'b1, "a0b0c1");
    do_op(4'd15, 4'd15, 1'b0, "a15b15");

    // Start held high, new operands presented in each DONE cycle.
    @(negedge clk);
    start = 1'b1; a = pa[0]; b = pb[0]; bin = pc[0];
    last = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      w = 0;
      while (!done && w < 20) begin
        w++;
        @(negedge clk);
      end
      exp = {1'b0, pa[k]} - {1'b0, pb[k]} - {4'b0, pc[k]};
      check_val("b2b_done", done, 1);
      check_val("b2b_res", {bout, diff}, exp);
      if (k > 0) check_val("b2b_gap", cycle - last, 5);
      last = cycle;
      if (k < 3) begin
        a = pa[k+1]; b = pb[k+1]; bin = pc[k+1];
      end else begin
        start = 1'b0;
      end
    end

    // Start during SHIFT is ignored.
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a = 4'd9; b = 4'd3; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 4'd1; b = 4'd14; bin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!done && w < 20) begin
      w++;
      @(negedge clk);
    end
    check_val("ignore_res", {done, bout, diff}, 6'h26);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    check_val("ignore_no_second", pulses, 0);

    // Async reset mid-SHIFT after a result of 6.
    start = 1'b1; a = 4'd15; b = 4'd1; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rst_async", {busy, done, bout, diff}, 7'h00);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    check_val("rst_no_done", pulses, 0);
    do_op(4'd3, 4'd9, 1'b0, "after_rst");

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      do_op(v[7:4], v[3:0], v[8], "sweep");
    end

    do_op8(8'h00, 8'h01, 1'b0, "w8_wrap");
    do_op8(8'hC8, 8'h37, 1'b1, "w8_dir");
    for (int i = 0; i < 20; i++) begin
      do_op8(8'($urandom), 8'($urandom), 1'($urandom), "w8_rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
